// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Round-robin arbiter that shares the single register-file write port among
// NREQ writeback requesters (ALU, load unit, mult/div). The winning request
// is captured into one registered output stage that drives regwrite/rd/
// writedata. Writes to register 0 are accepted but never reach the regfile.
//
// Optional feature (macro REGFILE_SCOREBOARD_EN): a pending-write scoreboard
// that decode uses to stall on RAW hazards. Without the macro, the iss_* and
// chk_* inputs are ignored and both busy outputs are tied low.
//
// Ports
//   clk        core clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester valid
//   req_rd     per-requester destination (slice i*AW +: AW)
//   req_data   per-requester write data (slice i*DW +: DW)
//   req_ready  one-hot grant; transfer happens when valid & ready
//   regwrite   regfile write enable (registered)
//   rd         regfile write address (registered)
//   writedata  regfile write data (registered)
//   grant_id   index of the requester behind the current regwrite
//   iss_valid  decode issues an instruction writing iss_rd
//   iss_rd     destination of the issued instruction
//   chk_rs1    source register 1 to check
//   chk_rs2    source register 2 to check
//   rs1_busy   chk_rs1 still has a write pending
//   rs2_busy   chk_rs2 still has a write pending
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               regwrite,
    output logic [AW-1:0]      rd,
    output logic [DW-1:0]      writedata,
    output logic [2:0]         grant_id,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    input  logic [AW-1:0]      chk_rs1,
    input  logic [AW-1:0]      chk_rs2,
    output logic               rs1_busy,
    output logic               rs2_busy
);

    localparam int NREG = 1 << AW;

    logic [2:0]         ptr_reg;
    logic [2:0]         ptr_next;
    logic               regwrite_reg;
    logic [AW-1:0]      rd_reg;
    logic [DW-1:0]      writedata_reg;
    logic [2:0]         grant_id_reg;

    logic [2*NREQ-1:0]  valid_dbl;
    logic [NREQ-1:0]    valid_rot;
    logic               grant_found;
    logic [2:0]         grant_offs;
    logic [3:0]         grant_sum;
    logic [2:0]         grant_idx;
    logic [AW-1:0]      sel_rd;
    logic [DW-1:0]      sel_data;

    // Rotate the valid vector so that bit 0 is the requester at ptr; the
    // first set bit is then the offset of the winner from ptr.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = NREQ'(valid_dbl >> ptr_reg);

    always_comb begin
        grant_found = 1'b0;
        grant_offs  = 3'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_found && valid_rot[j]) begin
                grant_found = 1'b1;
                grant_offs  = 3'(j);
            end
        end
        grant_sum = {1'b0, ptr_reg} + {1'b0, grant_offs};
        if (grant_sum >= 4'(NREQ)) begin
            grant_sum = grant_sum - 4'(NREQ);
        end
        grant_idx = grant_sum[2:0];
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_found && (grant_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_found) begin
            ptr_next = (grant_idx == 3'(NREQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // The write port never back-pressures, so any grant is a transfer.
    // A transfer to register 0 still advances ptr but does not write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= 3'd0;
            regwrite_reg  <= 1'b0;
            rd_reg        <= '0;
            writedata_reg <= '0;
            grant_id_reg  <= 3'd0;
        end else begin
            ptr_reg      <= ptr_next;
            regwrite_reg <= grant_found && (sel_rd != '0);
            if (grant_found) begin
                rd_reg        <= sel_rd;
                writedata_reg <= sel_data;
                grant_id_reg  <= grant_idx;
            end
        end
    end

    assign regwrite  = regwrite_reg;
    assign rd        = rd_reg;
    assign writedata = writedata_reg;
    assign grant_id  = grant_id_reg;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;

    // Issue is applied after the clear so that a new producer of the same
    // register wins over the retiring one.
    always_comb begin
        pending_next = pending_reg;
        if (regwrite_reg) begin
            pending_next[rd_reg] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            pending_next[iss_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign rs1_busy = (chk_rs1 != '0) && pending_reg[chk_rs1];
    assign rs2_busy = (chk_rs2 != '0) && pending_reg[chk_rs2];
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, chk_rs1, chk_rs2};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule
